// File: rtl/eth_phy_10g_link_ctrl_if.sv
// XGMII receive-path bundle: decoded PCS data in, filtered MAC-side data out.
// The link controller is the slave; the PCS/MAC side (or a bench) is the master.
interface eth_phy_10g_link_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] pcs_rxd;
   logic [CTRL_WIDTH-1:0] pcs_rxc;
   logic [DATA_WIDTH-1:0] xgmii_rxd;
   logic [CTRL_WIDTH-1:0] xgmii_rxc;

   modport master (
      output pcs_rxd,
      output pcs_rxc,
      input  xgmii_rxd,
      input  xgmii_rxc
   );

   modport slave (
      input  pcs_rxd,
      input  pcs_rxc,
      output xgmii_rxd,
      output xgmii_rxc
   );
endinterface

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY receive link controller: waits for block lock, qualifies link stability,
// issues SERDES RX reset pulses on timeout/link loss, and gates XGMII data to the MAC.
module eth_phy_10g_link_ctrl #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned CTRL_WIDTH    = DATA_WIDTH / 8,
   parameter int unsigned LOCK_TIMEOUT  = 1024,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned RST_PULSE_LEN = 4
) (
   input  logic                   rx_clk,
   input  logic                   rx_rst,
   input  logic                   cfg_enable,
   input  logic                   rx_block_lock,
   input  logic                   rx_high_ber,
   eth_phy_10g_link_ctrl_if.slave xgmii,
   output logic                   serdes_rx_reset_req,
   output logic                   link_up,
   output logic [7:0]             retrain_count,
   output logic [2:0]             state
);

   localparam int unsigned MaxAB  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
   localparam int unsigned MaxCnt = (MaxAB > RST_PULSE_LEN) ? MaxAB : RST_PULSE_LEN;
   localparam int unsigned TimerW = $clog2(MaxCnt + 1);

   // Local fault ordered set on both lanes.
   localparam logic [DATA_WIDTH-1:0] LfData = 64'h0100009C0100009C;
   localparam logic [CTRL_WIDTH-1:0] LfCtrl = 8'h11;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StUp       = 3'd3,
      StRxReset  = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [TimerW-1:0]     timer_q, timer_d;
   logic [7:0]            retrain_q, retrain_d;
   logic                  link_up_q;
   logic                  rst_req_q;
   logic [DATA_WIDTH-1:0] rxd_q;
   logic [CTRL_WIDTH-1:0] rxc_q;
   logic                  good;

   assign good = rx_block_lock & ~rx_high_ber;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retrain_d = retrain_q;
      if (!cfg_enable) begin
         state_d = StIdle;
         timer_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StWaitLock;
               timer_d = '0;
            end
            StWaitLock: begin
               if (good) begin
                  state_d = StStable;
                  timer_d = '0;
               end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
                  state_d = StRxReset;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TimerW'(1);
               end
            end
            StStable: begin
               if (!good) begin
                  state_d = StWaitLock;
                  timer_d = '0;
               end else if (timer_q == TimerW'(STABLE_CYCLES - 1)) begin
                  state_d = StUp;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TimerW'(1);
               end
            end
            StUp: begin
               if (!good) begin
                  state_d = StRxReset;
                  timer_d = '0;
                  if (retrain_q != 8'hFF) begin
                     retrain_d = retrain_q + 8'd1;
                  end
               end
            end
            StRxReset: begin
               // Line inputs are ignored for the full pulse width.
               if (timer_q == TimerW'(RST_PULSE_LEN - 1)) begin
                  state_d = StWaitLock;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TimerW'(1);
               end
            end
            default: begin
               state_d = StIdle;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         retrain_q <= '0;
         link_up_q <= 1'b0;
         rst_req_q <= 1'b0;
         rxd_q     <= LfData;
         rxc_q     <= LfCtrl;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retrain_q <= retrain_d;
         link_up_q <= (state_d == StUp);
         rst_req_q <= (state_d == StRxReset);
         // Gated by the registered link status, so the first UP cycle still emits fault.
         if (link_up_q) begin
            rxd_q <= xgmii.pcs_rxd;
            rxc_q <= xgmii.pcs_rxc;
         end else begin
            rxd_q <= LfData;
            rxc_q <= LfCtrl;
         end
      end
   end

   assign xgmii.xgmii_rxd     = rxd_q;
   assign xgmii.xgmii_rxc     = rxc_q;
   assign serdes_rx_reset_req = rst_req_q;
   assign link_up             = link_up_q;
   assign retrain_count       = retrain_q;
   assign state               = state_q;

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Bench for the 10G link controller: random data/line conditions against an
// event-level reference model, plus directed timing checks for the main scenarios.
module tb_eth_phy_10g_link_ctrl;

   localparam int LockTimeout = 1024;
   localparam int StableCycles = 16;
   localparam int PulseLen = 4;
   localparam logic [63:0] LfD = 64'h0100009C0100009C;
   localparam logic [7:0] LfC = 8'h11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       lock = 1'b0;
   logic       ber = 1'b0;
   logic       req;
   logic       lup;
   logic [7:0] rcnt;
   logic [2:0] st;

   int asserts = 0;
   int fails = 0;
   bit fixed_data = 1'b0;

   eth_phy_10g_link_ctrl_if bus ();

   eth_phy_10g_link_ctrl #(
      .DATA_WIDTH   (64),
      .CTRL_WIDTH   (8),
      .LOCK_TIMEOUT (LockTimeout),
      .STABLE_CYCLES(StableCycles),
      .RST_PULSE_LEN(PulseLen)
   ) dut (
      .rx_clk             (clk),
      .rx_rst             (rst),
      .cfg_enable         (en),
      .rx_block_lock      (lock),
      .rx_high_ber        (ber),
      .xgmii              (bus),
      .serdes_rx_reset_req(req),
      .link_up            (lup),
      .retrain_count      (rcnt),
      .state              (st)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: mode 0 idle, 1 waiting for lock, 2 qualifying, 3 up, 4 reset pulse.
   int          m_mode = 0;
   int          m_wait = 0;
   int          m_run = 0;
   int          m_left = 0;
   int          m_retrain = 0;
   bit          m_link = 1'b0;
   logic [63:0] m_xd = LfD;
   logic [7:0]  m_xc = LfC;

   task automatic model_edge();
      bit g;
      g = lock && !ber;
      if (m_link) begin
         m_xd = bus.pcs_rxd;
         m_xc = bus.pcs_rxc;
      end else begin
         m_xd = LfD;
         m_xc = LfC;
      end
      if (rst) begin
         m_mode = 0;
         m_retrain = 0;
         m_xd = LfD;
         m_xc = LfC;
      end else if (!en) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: begin m_mode = 1; m_wait = 0; end
            1: begin
               if (g) begin
                  m_mode = 2;
                  m_run = 0;
               end else begin
                  m_wait++;
                  if (m_wait == LockTimeout) begin m_mode = 4; m_left = PulseLen; end
               end
            end
            2: begin
               if (!g) begin
                  m_mode = 1;
                  m_wait = 0;
               end else begin
                  m_run++;
                  if (m_run == StableCycles) m_mode = 3;
               end
            end
            3: begin
               if (!g) begin
                  m_mode = 4;
                  m_left = PulseLen;
                  if (m_retrain < 255) m_retrain++;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) begin m_mode = 1; m_wait = 0; end
            end
         endcase
      end
      m_link = (m_mode == 3);
   endtask

   function automatic logic [84:0] dut_bus();
      return {st, lup, req, rcnt, bus.xgmii_rxd, bus.xgmii_rxc};
   endfunction

   function automatic logic [84:0] exp_bus();
      return {3'(m_mode), m_link, (m_mode == 4), 8'(m_retrain), m_xd, m_xc};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (!fixed_data) begin
         bus.pcs_rxd = {$urandom, $urandom};
         bus.pcs_rxc = 8'($urandom);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0;
      step();
      step();
      asserts++;
      if ({st, lup, req, rcnt, bus.xgmii_rxd, bus.xgmii_rxc} !== {3'd0, 1'b0, 1'b0, 8'd0, LfD, LfC}) begin
         fails++;
         $display("FAIL reset_values: got %h required %h", dut_bus(),
                  {3'd0, 1'b0, 1'b0, 8'd0, LfD, LfC});
      end
      rst = 1'b0;
      step();
      asserts++;
      if (st !== 3'd0) begin
         fails++;
         $display("FAIL idle_hold: state %0d required 0", st);
      end
   endtask

   task automatic test_bringup();
      int n;
      fixed_data = 1'b1;
      bus.pcs_rxd = 64'hCAFEBABECAFEBABE;
      bus.pcs_rxc = 8'h00;
      en = 1'b1;
      lock = 1'b1;
      ber = 1'b0;
      n = 0;
      while (lup !== 1'b1 && n < 40) begin
         step();
         n++;
         asserts++;
         if (dut_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL bringup_model cyc=%0d: got %h required %h", n, dut_bus(), exp_bus());
         end
      end
      asserts++;
      if (n != 1 + 1 + StableCycles) begin
         fails++;
         $display("FAIL bringup_latency: link_up after %0d cycles, required %0d", n,
                  2 + StableCycles);
      end
      asserts++;
      if (bus.xgmii_rxc !== LfC) begin
         fails++;
         $display("FAIL first_up_fault: rxc %h required %h", bus.xgmii_rxc, LfC);
      end
      step();
      asserts++;
      if ({bus.xgmii_rxd, bus.xgmii_rxc} !== {64'hCAFEBABECAFEBABE, 8'h00}) begin
         fails++;
         $display("FAIL passthrough_first: got %h/%h required cafebabecafebabe/00",
                  bus.xgmii_rxd, bus.xgmii_rxc);
      end
      fixed_data = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         asserts++;
         if (dut_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL passthrough_rand cyc=%0d: got %h required %h", i, dut_bus(), exp_bus());
         end
      end
   endtask

   task automatic test_link_loss();
      int n;
      ber = 1'b1;
      step();
      ber = 1'b0;
      asserts++;
      if ({st, req, lup, rcnt} !== {3'd4, 1'b1, 1'b0, 8'd1}) begin
         fails++;
         $display("FAIL loss_enter: state/req/up/cnt %0d/%0d/%0d/%0d required 4/1/0/1",
                  st, req, lup, rcnt);
      end
      step();
      asserts++;
      if (bus.xgmii_rxc !== LfC) begin
         fails++;
         $display("FAIL loss_fault: rxc %h required %h", bus.xgmii_rxc, LfC);
      end
      n = 0;
      while (lup !== 1'b1 && n < 60) begin
         step();
         n++;
         asserts++;
         if (dut_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL relock_model cyc=%0d: got %h required %h", n, dut_bus(), exp_bus());
         end
      end
      asserts++;
      if (lup !== 1'b1) begin
         fails++;
         $display("FAIL relock: link_up %b required 1", lup);
      end
   endtask

   task automatic test_glitch();
      int n;
      en = 1'b0;
      step();
      en = 1'b1;
      lock = 1'b1;
      n = 0;
      while (m_mode != 2 && n < 10) begin
         step();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         asserts++;
         if (dut_bus() !== exp_bus() || lup !== 1'b0) begin
            fails++;
            $display("FAIL glitch_stable cyc=%0d: got %h required %h", i, dut_bus(), exp_bus());
         end
      end
      lock = 1'b0;
      step();
      lock = 1'b1;
      asserts++;
      if ({st, lup} !== {3'd1, 1'b0}) begin
         fails++;
         $display("FAIL glitch_back: state/up %0d/%0d required 1/0", st, lup);
      end
      n = 0;
      while (lup !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      asserts++;
      if (n != 1 + StableCycles) begin
         fails++;
         $display("FAIL glitch_requalify: link_up after %0d cycles, required %0d", n,
                  1 + StableCycles);
      end
   endtask

   task automatic test_timeout();
      int first;
      int second;
      int highs;
      logic prev;
      logic [7:0] r0;
      en = 1'b0;
      step();
      lock = 1'b0;
      en = 1'b1;
      r0 = rcnt;
      first = -1;
      second = -1;
      highs = 0;
      prev = 1'b0;
      for (int i = 1; i <= 2060; i++) begin
         step();
         asserts++;
         if (dut_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL timeout_model cyc=%0d: got %h required %h", i, dut_bus(), exp_bus());
         end
         if (req === 1'b1) highs++;
         if (req === 1'b1 && prev !== 1'b1) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
         prev = req;
      end
      asserts++;
      if (first != 1 + LockTimeout || second != 1 + 2 * LockTimeout + PulseLen) begin
         fails++;
         $display("FAIL timeout_period: pulses at %0d,%0d required %0d,%0d", first, second,
                  1 + LockTimeout, 1 + 2 * LockTimeout + PulseLen);
      end
      asserts++;
      if (highs != 2 * PulseLen || rcnt !== r0) begin
         fails++;
         $display("FAIL timeout_pulse: high cycles %0d cnt %0d required %0d cnt %0d", highs, rcnt,
                  2 * PulseLen, r0);
      end
   endtask

   task automatic test_saturation();
      int n;
      lock = 1'b1;
      ber = 1'b0;
      en = 1'b1;
      for (int k = 0; k < 300; k++) begin
         n = 0;
         while (lup !== 1'b1 && n < 60) begin
            step();
            n++;
            asserts++;
            if (dut_bus() !== exp_bus()) begin
               fails++;
               $display("FAIL sat_model loss=%0d: got %h required %h", k, dut_bus(), exp_bus());
            end
         end
         ber = 1'b1;
         step();
         ber = 1'b0;
      end
      asserts++;
      if (rcnt !== 8'd255 || st !== 3'd4) begin
         fails++;
         $display("FAIL saturate: cnt %0d state %0d required 255 / 4", rcnt, st);
      end
      en = 1'b0;
      step();
      asserts++;
      if ({st, req, rcnt} !== {3'd0, 1'b0, 8'd255}) begin
         fails++;
         $display("FAIL disable_in_reset: state/req/cnt %0d/%0d/%0d required 0/0/255", st, req,
                  rcnt);
      end
      en = 1'b1;
   endtask

   task automatic test_mid_reset();
      int n;
      lock = 1'b1;
      ber = 1'b0;
      n = 0;
      while (lup !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      asserts++;
      if ({st, lup, req, rcnt, bus.xgmii_rxd, bus.xgmii_rxc} !== {3'd0, 1'b0, 1'b0, 8'd0, LfD, LfC}) begin
         fails++;
         $display("FAIL mid_reset: got %h required %h", dut_bus(),
                  {3'd0, 1'b0, 1'b0, 8'd0, LfD, LfC});
      end
      n = 0;
      while (lup !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      asserts++;
      if (n != 2 + StableCycles) begin
         fails++;
         $display("FAIL rebringup: link_up after %0d cycles, required %0d", n, 2 + StableCycles);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         lock = ($urandom_range(0, 15) != 0);
         ber = ($urandom_range(0, 31) == 0);
         en = ($urandom_range(0, 199) != 0);
         rst = ($urandom_range(0, 299) == 0);
         step();
         asserts++;
         if (dut_bus() !== exp_bus()) begin
            fails++;
            $display("FAIL random cyc=%0d: got %h required %h", i, dut_bus(), exp_bus());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.pcs_rxd = '0;
      bus.pcs_rxc = '0;
      test_reset();
      test_bringup();
      test_link_loss();
      test_glitch();
      test_timeout();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
ETH_PHY_10G_LINK_CTRL -- requirements
Module: eth_phy_10g_link_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the XGMII data width; only 64 is supported.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 8, meaning the XGMII control width, equal to DATA_WIDTH/8.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 1024, meaning the number of cycles to wait for lock before forcing an RX reset.
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 16, meaning the number of consecutive good cycles required before link-up.
REQ-005 The block SHALL have parameter RST_PULSE_LEN, default 4, meaning the width of the reset-request pulse in cycles.
REQ-006 Port rx_clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-007 Port rx_rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port cfg_enable, input, 1 bit: controller enable.
REQ-009 Port rx_block_lock, input, 1 bit: block lock from the PCS frame sync.
REQ-010 Port rx_high_ber, input, 1 bit: high-BER indication from the PCS BER monitor.
REQ-011 Port pcs_rxd / pcs_rxc, input, 64 / 8 bits: decoded XGMII data/control from the PCS receiver.
REQ-012 Port xgmii_rxd / xgmii_rxc, output, 64 / 8 bits: filtered XGMII data/control to the MAC.
REQ-013 Port serdes_rx_reset_req, output, 1 bit: reset request to the SERDES receiver.
REQ-014 Port link_up, output, 1 bit: link status.
REQ-015 Port retrain_count, output, 8 bits: saturating count of link-loss events.
REQ-016 Port state, output, 3 bits: current FSM state encoding.

Function
REQ-017 The FSM SHALL use these states: IDLE=0, WAIT_LOCK=1, STABLE=2, UP=3, RX_RESET=4.
REQ-018 IDLE: if cfg_enable=1, go to WAIT_LOCK on the next cycle and clear the timer; otherwise stay in IDLE.
REQ-019 WAIT_LOCK: the timer SHALL increment every cycle.
  - good = rx_block_lock & ~rx_high_ber.
  - If good: go to STABLE with timer=0.
  - Else if timer = LOCK_TIMEOUT-1: go to RX_RESET with timer=0.
  - Good takes priority over timeout in the same cycle.
REQ-020 STABLE: the timer SHALL count consecutive good cycles.
  - Any non-good cycle: go to WAIT_LOCK with timer=0.
  - Timer reaching STABLE_CYCLES-1 while good: go to UP.
REQ-021 UP: any non-good cycle SHALL move to RX_RESET and increment retrain_count; retrain_count saturates at 255.
REQ-022 RX_RESET: serdes_rx_reset_req=1 for exactly RST_PULSE_LEN cycles, then go to WAIT_LOCK with timer=0; inputs are ignored during the pulse.
REQ-023 cfg_enable=0 in any state SHALL force IDLE on the next cycle.
  - An in-progress reset pulse is truncated.
  - retrain_count is held.
REQ-024 All outputs SHALL be registered, with these values:
  - link_up=1 exactly while state=UP.
  - serdes_rx_reset_req=1 exactly while state=RX_RESET.
  - state reflects the current state register.
REQ-025 Data filter latency SHALL be 1 cycle.
  - While the registered link_up=1: xgmii_rxd/xgmii_rxc = pcs_rxd/pcs_rxc of the previous cycle.
  - Otherwise: xgmii_rxd=64'h0100009C0100009C and xgmii_rxc=8'h11 (local fault ordered set on both lanes).
REQ-026 On the first UP cycle the filter SHALL still output local fault; passthrough begins the following cycle.
REQ-027 The timer SHALL be wide enough for max(LOCK_TIMEOUT, STABLE_CYCLES, RST_PULSE_LEN) and SHALL never wrap.

Reset
REQ-028 When rx_rst=1 at a clock edge, the block SHALL set:
  - state=IDLE, timer=0, retrain_count=0;
  - link_up=0, serdes_rx_reset_req=0;
  - xgmii_rxd=64'h0100009C0100009C, xgmii_rxc=8'h11.
REQ-029 rx_rst SHALL override all other inputs, including mid-pulse in RX_RESET, where the pulse deasserts on the next cycle.

Verification
REQ-030 Bring-up: enable=1, lock=1, high_ber=0 from cycle 0 -> link_up rises after 1+1+16 cycles (IDLE, WAIT_LOCK, STABLE); pcs_rxd=64'hCAFEBABECAFEBABE appears on xgmii_rxd one cycle later.
REQ-031 Timeout: lock held 0 -> serdes_rx_reset_req high for 4 cycles starting 1024 cycles after entering WAIT_LOCK; repeats every 1028 cycles; retrain_count stays 0.
REQ-032 Link loss: from UP, assert high_ber for 1 cycle -> RX_RESET, retrain_count=1, xgmii_rxc=8'h11 within 1 cycle; relock recovers to UP.
REQ-033 Glitch in STABLE: drop lock at stable cycle 10 -> back to WAIT_LOCK, link_up never rises; the full 16 good cycles are required afterward.
REQ-034 Saturation and disable: force 300 link losses -> retrain_count=255; cfg_enable=0 in RX_RESET -> IDLE next cycle, pulse ends, retrain_count held.
REQ-035 Mid-operation reset: rx_rst=1 for 1 cycle while UP -> all outputs at reset values next cycle, then bring-up repeats.
